vga_blit_arbiter: RTL and testbench

- Sits in front of port A of the 2048x32 VGA text RAM and shares that single port between the CPU bus and a local blit engine.
- The blit engine performs screen fill and one-line scroll-up without CPU involvement.
- Port B (scanout) is not touched by this block.
- The RAM port has byte write enables and a 1-cycle registered read that updates only when enabled.

---
 rtl/vga_blit_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_vga_blit_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_blit_arbiter.sv
// vga_blit_arbiter
//   Shares port A of the 2048x32 VGA text RAM between the CPU bus and a local
//   blit engine that performs a whole-screen fill or a one-row scroll-up.
//   Port B (scanout) is not touched here.
//
//   Optional feature macro: VGA_BLIT_STALL_EN
//     undefined : CPU has absolute priority; the engine only issues in cycles
//                 with cpu_en=0; cpu_stall is constant 0.
//     defined   : while busy the engine owns the port every cycle; CPU
//                 requests are stalled (cpu_stall=cpu_en) and not forwarded.
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     cpu_en/we/addr/wd           CPU request (we==0 means read)
//     cpu_rd, cpu_rd_valid        CPU read data (ram_rd) and its valid strobe
//     cpu_stall                   CPU request not accepted this cycle
//     cmd_valid/ready/op/fill     blit command handshake: a command is taken
//                                 in a cycle where cmd_valid && cmd_ready;
//                                 cmd_ready is high only while idle, so
//                                 requests made while busy are ignored
//     busy, done                  engine active, one-cycle completion pulse
//     ram_en/we/addr/wd, ram_rd   RAM port A (1-cycle registered read)
//     dbg_state                   current engine state for observation
module vga_blit_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int ROW_WORDS = 40,
    parameter int ROWS      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_rd_valid,
    output logic              cpu_stall,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd,
    output logic [2:0]        dbg_state
);

    localparam int TOTAL = ROW_WORDS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(TOTAL - ROW_WORDS - 1);
    localparam logic [ADDR_W-1:0] ROW_A    = ADDR_W'(ROW_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_SCR_RD  = 3'd2,
        S_SCR_WR  = 3'd3,
        S_SCR_CLR = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] hold_q;
    logic              rd_pend;   // engine read was issued last cycle
    logic              eng_req;
    logic              eng_grant;
    logic              cpu_grant;

    assign dbg_state = state;
    assign cpu_rd    = ram_rd;

    always_comb begin
        eng_req = (state == S_FILL) || (state == S_SCR_RD) ||
                  (state == S_SCR_WR) || (state == S_SCR_CLR);
    end

    // The engine is never granted while rst is high, so a reset that lands
    // mid-command produces no further engine writes.
`ifdef VGA_BLIT_STALL_EN
    assign cpu_grant = cpu_en && !busy;
    assign cpu_stall = cpu_en && busy;
    assign eng_grant = eng_req && !rst;
`else
    assign cpu_grant = cpu_en;
    assign cpu_stall = 1'b0;
    assign eng_grant = eng_req && !cpu_en && !rst;
`endif

    // Port mux. In the write half of a scroll pair the read data may still
    // be on ram_rd (hold captures it at the end of this cycle), so forward it.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 4'h0;
        ram_addr = '0;
        ram_wd   = '0;
        if (cpu_grant) begin
            ram_en   = 1'b1;
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_wd   = cpu_wd;
        end else if (eng_grant) begin
            ram_en = 1'b1;
            case (state)
                S_FILL, S_SCR_CLR: begin
                    ram_we   = 4'hF;
                    ram_addr = ptr;
                    ram_wd   = fill_q;
                end
                S_SCR_RD: begin
                    ram_we   = 4'h0;
                    ram_addr = ptr + ROW_A;
                end
                S_SCR_WR: begin
                    ram_we   = 4'hF;
                    ram_addr = ptr;
                    ram_wd   = rd_pend ? ram_rd : hold_q;
                end
                default: begin
                    ram_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            fill_q       <= '0;
            hold_q       <= '0;
            rd_pend      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmd_ready    <= 1'b1;
            cpu_rd_valid <= 1'b0;
        end else begin
            cpu_rd_valid <= cpu_grant && (cpu_we == 4'h0);
            rd_pend      <= eng_grant && (state == S_SCR_RD);
            // Capture the engine's read data the cycle after it was issued,
            // whoever owns the port in this cycle.
            if (rd_pend) begin
                hold_q <= ram_rd;
            end
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        fill_q    <= cmd_fill;
                        ptr       <= '0;
                        state     <= cmd_op ? S_SCR_RD : S_FILL;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                S_FILL, S_SCR_CLR: begin
                    if (eng_grant) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST_A) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_SCR_RD: begin
                    if (eng_grant) begin
                        state <= S_SCR_WR;
                    end
                end
                S_SCR_WR: begin
                    if (eng_grant) begin
                        ptr   <= ptr + 1'b1;
                        state <= (ptr == SCR_LAST) ? S_SCR_CLR : S_SCR_RD;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_blit_arbiter.sv
module tb_vga_blit_arbiter;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 32;
    localparam int ROW_WORDS = 40;
    localparam int ROWS      = 30;
    localparam int TOTAL     = ROW_WORDS * ROWS;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_en;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd;
    logic [DATA_W-1:0] cpu_rd;
    logic              cpu_rd_valid;
    logic              cpu_stall;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [DATA_W-1:0] cmd_fill;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wd;
    logic [DATA_W-1:0] ram_rd = '0;
    logic [2:0]        dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vga_blit_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_WORDS(ROW_WORDS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_rd_valid(cpu_rd_valid), .cpu_stall(cpu_stall),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_fill(cmd_fill), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
        .ram_rd(ram_rd), .dbg_state(dbg_state)
    );

    // RAM port A: byte enables, registered read-first output updated on enable.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rd <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [0:TOTAL-1];

    function automatic void ref_fill(input logic [DATA_W-1:0] v);
        for (int k = 0; k < TOTAL; k++) ref_mem[k] = v;
    endfunction

    function automatic void ref_scroll(input logic [DATA_W-1:0] v);
        for (int k = 0; k < TOTAL - ROW_WORDS; k++) ref_mem[k] = ref_mem[k + ROW_WORDS];
        for (int k = TOTAL - ROW_WORDS; k < TOTAL; k++) ref_mem[k] = v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_image(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < TOTAL; k++) if (mem[k] !== ref_mem[k]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    // Monitor: pops expected CPU read data whenever the DUT flags it valid.
    int done_cnt  = 0;
    int stall_cnt = 0;
    int leak_cnt  = 0;
    logic eng_rd_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_rd_valid) begin
                if (exp_q.size() == 0) chk("cpu_rd_unexpected", 64'd1, 64'd0);
                else chk("cpu_rd", 64'(cpu_rd), 64'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
`ifdef VGA_BLIT_STALL_EN
            if (busy && cpu_en && !cpu_stall) stall_cnt++;
            if (busy && ram_en && ram_we != 4'h0 && ram_wd == cpu_wd && cpu_en) leak_cnt++;
`else
            if (cpu_stall) stall_cnt++;
`endif
        end
        eng_rd_seen = ram_en && !cpu_en && (ram_we == 4'h0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_en = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wd = '0;
    endtask

    // Load the screen through the CPU port; pattern 0: word k = k, 1: random.
    task automatic preload(input int pattern);
        for (int k = 0; k < TOTAL; k++) begin
            ref_mem[k] = (pattern == 0) ? DATA_W'(k) : DATA_W'($urandom);
            cpu_en = 1'b1; cpu_we = 4'hF; cpu_addr = ADDR_W'(k); cpu_wd = ref_mem[k];
            tick();
        end
        cpu_idle();
        tick();
    endtask

    // Present a command while idle; optionally keep cmd_valid high (with a
    // different op) for the first busy cycle to show it is ignored.
    task automatic issue(input logic op, input logic [DATA_W-1:0] v, input logic keep);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_fill = v;
        tick();
        cmd_valid = keep; cmd_op = ~op; cmd_fill = ~v;
    endtask

    // Cycle 1 is the first cycle after the accept edge.
    task automatic wait_done(input int budget, output int cyc, output int cpu_cycles);
        logic got;
        got = 1'b0; cyc = 0; cpu_cycles = 0;
        while (cyc < budget) begin
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            if (done) begin got = 1'b1; break; end
            if (cpu_en) cpu_cycles++;
            tick();
            cmd_valid = 1'b0;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
    endtask

    logic stop;

    // mode 1: read addr 5 every other cycle; mode 2: read a random address in
    // the cycle right after each engine read.
    task automatic cpu_driver(input int mode);
        logic ph;
        logic [ADDR_W-1:0] a;
        ph = 1'b0;
        while (!stop) begin
            cpu_idle();
            if (mode == 1) begin
                if (ph) begin
                    cpu_en = 1'b1; cpu_addr = ADDR_W'(5);
                    exp_q.push_back(mem[5]);
                end
                ph = ~ph;
            end else if (eng_rd_seen) begin
                a = ADDR_W'($urandom_range(0, TOTAL - 1));
                cpu_en = 1'b1; cpu_addr = a;
                exp_q.push_back(mem[a]);
            end
            tick();
        end
        cpu_idle();
    endtask

    task automatic scroll_with_cpu(input int mode, input int pattern);
        int cyc, cc, d0;
        logic [DATA_W-1:0] v;
        v = DATA_W'($urandom);
        preload(pattern);
        ref_scroll(v);
        d0 = done_cnt;
        stop = 1'b0;
        issue(1'b1, v, 1'b0);
        fork
            cpu_driver(mode);
            begin
                wait_done(6000, cyc, cc);
                stop = 1'b1;
            end
        join
        tick(); tick();
        chk("scroll_cpu_latency", 64'(cyc), 64'(2361 + cc));
        chk("scroll_cpu_cpu_cycles_seen", 64'(cc > 0), 64'd1);
        chk("scroll_cpu_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk_image("scroll_cpu_image");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc, cc, d0;
        logic [DATA_W-1:0] v;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_fill = '0; stop = 1'b0;
        cpu_idle();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cpu_rd_valid", 64'(cpu_rd_valid), 64'd0);
        chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Fill with blank attribute word, no CPU traffic.
        d0 = done_cnt;
        ref_fill(32'h0720_0720);
        issue(1'b0, 32'h0720_0720, 1'b1);
        wait_done(3000, cyc, cc);
        tick();
        chk("fill_latency", 64'(cyc), 64'd1201);
        chk("fill_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk_image("fill_image");

        // Scroll of the k pattern, no CPU traffic.
        preload(0);
        ref_scroll('0);
        d0 = done_cnt;
        issue(1'b1, '0, 1'b0);
        wait_done(6000, cyc, cc);
        tick();
        chk("scroll_latency", 64'(cyc), 64'd2361);
        chk("scroll_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("scroll_word0", 64'(mem[0]), 64'd40);
        chk("scroll_word1159", 64'(mem[1159]), 64'd1199);
        chk("scroll_word1160", 64'(mem[1160]), 64'd0);
        chk_image("scroll_image");

`ifndef VGA_BLIT_STALL_EN
        scroll_with_cpu(1, 0);
        scroll_with_cpu(2, 1);
`endif

        // Reset in the cycle where the fill pointer is 600.
        preload(1);
        v = 32'h1111_2222;
        for (int k = 0; k < 600; k++) ref_mem[k] = v;
        issue(1'b0, v, 1'b0);
        repeat (600) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_write", 64'(ram_en), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ram_en", 64'(ram_en), 64'd0);
        tick(); tick();
        chk_image("rst_mid_image");

`ifdef VGA_BLIT_STALL_EN
        // CPU keeps trying to write addr 0 during a fill.
        v = 32'h5555_AAAA;
        ref_fill(v);
        ref_mem[0] = 32'hDEAD_BEEF;
        d0 = done_cnt;
        issue(1'b0, v, 1'b0);
        cpu_en = 1'b1; cpu_we = 4'hF; cpu_addr = '0; cpu_wd = 32'hDEAD_BEEF;
        wait_done(3000, cyc, cc);
        @(negedge clk);
        chk("stall_idle_no_stall", 64'(cpu_stall), 64'd0);
        tick();
        cpu_idle();
        tick();
        chk("stall_fill_latency", 64'(cyc), 64'd1201);
        chk("stall_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("stall_asserted_while_busy", 64'(stall_cnt), 64'd0);
        chk("stall_no_cpu_write_while_busy", 64'(leak_cnt), 64'd0);
        chk_image("stall_image");
`else
        chk("cpu_stall_always_zero", 64'(stall_cnt), 64'd0);
`endif

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
